// File: rtl/alu_sequencer.sv
// Multi-cycle Z8 ALU sequencer: fetches operands, drives the external
// combinational ALU (chaining passes for INCW/DECW and DA), writes results
// back and owns the architectural FLAGS register.
module alu_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ready,
  output logic       done,
  input  logic [4:0] op,
  input  logic [7:0] dst,
  input  logic [7:0] src,
  input  logic       srcImm,
  output logic [7:0] regAddr,
  input  logic [7:0] regRdData,
  output logic [7:0] regWrData,
  output logic       regWe,
  output logic [4:0] aluMode,
  output logic [7:0] aluA,
  output logic [7:0] aluB,
  output logic [7:0] aluFlags,
  input  logic [7:0] aluOut,
  input  logic [7:0] aluOutFlags,
  input  logic [7:0] flagsIn,
  input  logic       flagsWe,
  output logic [7:0] flags
);

  // ALU mode codes (alu.vh): two-operand ops have op[4]=0.
  localparam logic [4:0] ALU2_ADD  = 5'h00;
  localparam logic [4:0] ALU2_ADC  = 5'h01;
  localparam logic [4:0] ALU2_SUB  = 5'h02;
  localparam logic [4:0] ALU2_SBC  = 5'h03;
  localparam logic [4:0] ALU2_OR   = 5'h04;
  localparam logic [4:0] ALU2_AND  = 5'h05;
  localparam logic [4:0] ALU2_TCM  = 5'h06;
  localparam logic [4:0] ALU2_TM   = 5'h07;
  localparam logic [4:0] ALU2_CP   = 5'h08;
  localparam logic [4:0] ALU2_XOR  = 5'h09;
  localparam logic [4:0] ALU1_LD   = 5'h10;
  localparam logic [4:0] ALU1_CLR  = 5'h11;
  localparam logic [4:0] ALU1_COM  = 5'h12;
  localparam logic [4:0] ALU1_INC  = 5'h13;
  localparam logic [4:0] ALU1_DEC  = 5'h14;
  localparam logic [4:0] ALU1_DA   = 5'h15;
  localparam logic [4:0] ALU1_DA_H = 5'h16;
  localparam logic [4:0] ALU1_INCW = 5'h17;
  localparam logic [4:0] ALU1_DECW = 5'h18;

  typedef enum logic [2:0] {
    IDLE, RD_SRC, RD_DST, EXEC, RD_HI, EXEC_HI, DA_H
  } state_t;

  state_t     state, next;
  logic [4:0] op_q;
  logic [7:0] dst_q, src_q;
  logic [7:0] src_val, dst_val, lo_q, t_q, f_q;
  logic [7:0] hi_addr, lo_addr;
  logic       final_cyc;

  function automatic logic is_word(input logic [4:0] m);
    return (m == ALU1_INCW) || (m == ALU1_DECW);
  endfunction

  function automatic logic is_alu2(input logic [4:0] m);
    return !m[4];
  endfunction

  function automatic logic no_wb(input logic [4:0] m);
    return (m == ALU2_CP) || (m == ALU2_TM) || (m == ALU2_TCM);
  endfunction

  assign hi_addr = {dst_q[7:1], 1'b0};
  assign lo_addr = {dst_q[7:1], 1'b1};
  assign ready   = (state == IDLE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next;
  end

  // Command latch, operand capture and intermediate-pass results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      src_val <= '0;
      dst_val <= '0;
      lo_q    <= '0;
      t_q     <= '0;
      f_q     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q    <= op;
          dst_q   <= dst;
          src_q   <= src;
          src_val <= src;
        end
        RD_SRC:        src_val <= regRdData;
        RD_DST, RD_HI: dst_val <= regRdData;
        EXEC: begin
          if (is_word(op_q)) lo_q <= aluOut;
          if (op_q == ALU1_DA) begin
            t_q <= aluOut;
            f_q <= aluOutFlags;
          end
        end
        default: ;
      endcase
    end
  end

  // FLAGS: ALU result on the final pass, external load only while idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 flags <= '0;
    else if (final_cyc)        flags <= aluOutFlags;
    else if (ready && flagsWe) flags <= flagsIn;
  end

  // Completion pulse in the cycle after the final ALU pass
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done <= 1'b0;
    else       done <= final_cyc;
  end

  // Next state, register-file and ALU drive
  always_comb begin
    next      = state;
    regAddr   = '0;
    regWrData = '0;
    regWe     = 1'b0;
    aluMode   = '0;
    aluA      = '0;
    aluB      = '0;
    aluFlags  = flags;
    final_cyc = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (op == ALU1_CLR)
          next = EXEC;
        else if (op == ALU1_LD)
          next = srcImm ? EXEC : RD_SRC;
        else if (is_alu2(op))
          next = srcImm ? RD_DST : RD_SRC;
        else
          next = RD_DST;
      end
      RD_SRC: begin
        regAddr = src_q;
        next    = (op_q == ALU1_LD) ? EXEC : RD_DST;
      end
      RD_DST: begin
        regAddr = is_word(op_q) ? lo_addr : dst_q;
        next    = EXEC;
      end
      EXEC: begin
        aluA = (op_q == ALU1_LD) ? src_val : dst_val;
        aluB = src_val;
        if (is_word(op_q)) begin
          // Low byte of the pair: plain INC/DEC, written but FLAGS untouched
          aluMode   = (op_q == ALU1_INCW) ? ALU1_INC : ALU1_DEC;
          regAddr   = lo_addr;
          regWe     = 1'b1;
          regWrData = aluOut;
          next      = RD_HI;
        end else if (op_q == ALU1_DA) begin
          aluMode = ALU1_DA;
          regAddr = dst_q;
          next    = DA_H;
        end else begin
          aluMode   = op_q;
          regAddr   = dst_q;
          regWe     = !no_wb(op_q);
          regWrData = regWe ? aluOut : '0;
          final_cyc = 1'b1;
          next      = IDLE;
        end
      end
      RD_HI: begin
        regAddr = hi_addr;
        next    = EXEC_HI;
      end
      EXEC_HI: begin
        aluMode   = (op_q == ALU1_INCW) ? ALU1_INCW : ALU1_DECW;
        aluA      = dst_val;
        aluB      = lo_q;
        regAddr   = hi_addr;
        regWe     = 1'b1;
        regWrData = aluOut;
        final_cyc = 1'b1;
        next      = IDLE;
      end
      DA_H: begin
        aluMode   = ALU1_DA_H;
        aluA      = t_q;
        aluFlags  = f_q;
        regAddr   = dst_q;
        regWe     = 1'b1;
        regWrData = {aluOut[7:4], t_q[3:0]};
        final_cyc = 1'b1;
        next      = IDLE;
      end
      default: next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural register file and ALU around the DUT,
// directed scenarios plus randomized commands against an instruction-level model.
module tb_alu_sequencer;

  localparam logic [4:0] ADD = 5'h00, ADC = 5'h01, SUB = 5'h02, SBC = 5'h03;
  localparam logic [4:0] OR_ = 5'h04, AND_ = 5'h05, TCM = 5'h06, TM = 5'h07;
  localparam logic [4:0] CP = 5'h08, XOR_ = 5'h09;
  localparam logic [4:0] LD = 5'h10, CLR = 5'h11, COM = 5'h12, INC = 5'h13;
  localparam logic [4:0] DEC = 5'h14, DA = 5'h15, DA_H = 5'h16;
  localparam logic [4:0] INCW = 5'h17, DECW = 5'h18;
  localparam int FC = 7, FZ = 6, FS = 5, FV = 4, FD = 3, FH = 2;

  logic       clk = 1'b0, reset, start, ready, done, srcImm, regWe, flagsWe;
  logic [4:0] op, aluMode;
  logic [7:0] dst, src, regAddr, regRdData, regWrData, aluA, aluB, aluFlags;
  logic [7:0] aluOut, aluOutFlags, flagsIn, flags;

  logic [7:0] rf [256];
  logic [7:0] ref_rf [256];
  logic [7:0] ref_flags;
  logic [7:0] wa_q[$], wd_q[$], ew_a[$], ew_d[$];
  logic       tb_we;
  logic [7:0] tb_wa, tb_wd;
  int         tests = 0, fails = 0;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .ready(ready), .done(done),
    .op(op), .dst(dst), .src(src), .srcImm(srcImm),
    .regAddr(regAddr), .regRdData(regRdData), .regWrData(regWrData), .regWe(regWe),
    .aluMode(aluMode), .aluA(aluA), .aluB(aluB), .aluFlags(aluFlags),
    .aluOut(aluOut), .aluOutFlags(aluOutFlags),
    .flagsIn(flagsIn), .flagsWe(flagsWe), .flags(flags)
  );

  always #5 clk = ~clk;

  // Combinational single-pass Z8 ALU: returns {result, flags}
  function automatic logic [15:0] alu_fn(input logic [4:0] m, input logic [7:0] a, b, f);
    logic [8:0] r9;
    logic [4:0] h5;
    logic [7:0] r, nf;
    logic       cin, hc;
    nf = f;
    r  = a;
    case (m)
      ADD, ADC: begin
        cin = (m == ADC) ? f[FC] : 1'b0;
        r9 = {1'b0, a} + {1'b0, b} + {8'd0, cin};
        h5 = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, cin};
        r = r9[7:0];
        nf[FC] = r9[8]; nf[FH] = h5[4]; nf[FD] = 1'b0;
        nf[FV] = (a[7] == b[7]) && (r[7] != a[7]);
        nf[FZ] = (r == 8'h00); nf[FS] = r[7];
      end
      SUB, SBC, CP: begin
        cin = (m == SBC) ? f[FC] : 1'b0;
        r9 = {1'b0, a} - {1'b0, b} - {8'd0, cin};
        h5 = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'd0, cin};
        r = r9[7:0];
        nf[FC] = r9[8];
        nf[FV] = (a[7] != b[7]) && (r[7] != a[7]);
        nf[FZ] = (r == 8'h00); nf[FS] = r[7];
        if (m != CP) begin nf[FH] = h5[4]; nf[FD] = 1'b1; end
      end
      OR_, AND_, XOR_, TM, TCM, COM: begin
        case (m)
          OR_:     r = a | b;
          AND_:    r = a & b;
          XOR_:    r = a ^ b;
          TM:      r = a & b;
          TCM:     r = ~a & b;
          default: r = ~a;
        endcase
        nf[FV] = 1'b0; nf[FZ] = (r == 8'h00); nf[FS] = r[7];
      end
      LD:  r = a;
      CLR: r = 8'h00;
      INC: begin r = a + 8'd1; nf[FV] = (a == 8'h7F); nf[FZ] = (r == 8'h00); nf[FS] = r[7]; end
      DEC: begin r = a - 8'd1; nf[FV] = (a == 8'h80); nf[FZ] = (r == 8'h00); nf[FS] = r[7]; end
      DA: begin
        if (!f[FD]) begin
          hc = f[FC] || (a > 8'h99);
          r  = a + (((f[FH]) || (a[3:0] > 4'd9)) ? 8'h06 : 8'h00);
        end else begin
          hc = f[FC];
          r  = a - (f[FH] ? 8'h06 : 8'h00);
        end
        nf[FC] = hc;
      end
      DA_H: begin
        r = f[FD] ? a - (f[FC] ? 8'h60 : 8'h00) : a + (f[FC] ? 8'h60 : 8'h00);
        nf[FZ] = (r == 8'h00); nf[FS] = r[7];
      end
      INCW: begin
        r = a + ((b == 8'h00) ? 8'd1 : 8'd0);
        nf[FZ] = (r == 8'h00) && (b == 8'h00); nf[FS] = r[7];
        nf[FV] = (a == 8'h7F) && (b == 8'h00);
      end
      DECW: begin
        r = a - ((b == 8'hFF) ? 8'd1 : 8'd0);
        nf[FZ] = (r == 8'h00) && (b == 8'h00); nf[FS] = r[7];
        nf[FV] = (a == 8'h80) && (b == 8'hFF);
      end
      default: ;
    endcase
    return {r, nf};
  endfunction

  always_comb {aluOut, aluOutFlags} = alu_fn(aluMode, aluA, aluB, aluFlags);
  assign regRdData = rf[regAddr];

  // Register file writes (DUT strobe or bench preload) and write log
  always @(posedge clk) begin
    if (regWe) begin
      rf[regAddr] <= regWrData;
      wa_q.push_back(regAddr);
      wd_q.push_back(regWrData);
    end
    if (tb_we) rf[tb_wa] <= tb_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    tb_we = 1'b1; tb_wa = a; tb_wd = d;
    @(posedge clk); #1;
    tb_we = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic load_flags(input logic [7:0] v);
    @(negedge clk);
    flagsWe = 1'b1; flagsIn = v;
    @(posedge clk); #1;
    flagsWe = 1'b0;
    ref_flags = v;
    check("flags_load", {24'd0, flags}, {24'd0, v});
  endtask

  // Instruction-level model: expected writes, FLAGS and done latency
  task automatic ref_exec(input logic [4:0] m, input logic [7:0] d, input logic [7:0] s,
                          input logic im, output int lat);
    logic [7:0]  sv, dv, hi, lo, r, a;
    logic [15:0] w, nw, rr;
    logic        hc;
    ew_a.delete(); ew_d.delete();
    sv = im ? s : ref_rf[s];
    dv = ref_rf[d];
    if (m == INCW || m == DECW) begin
      hi = {d[7:1], 1'b0}; lo = {d[7:1], 1'b1};
      w  = {ref_rf[hi], ref_rf[lo]};
      nw = (m == INCW) ? w + 16'd1 : w - 16'd1;
      ew_a.push_back(lo); ew_d.push_back(nw[7:0]);
      ew_a.push_back(hi); ew_d.push_back(nw[15:8]);
      ref_flags[FZ] = (nw == 16'h0000);
      ref_flags[FS] = nw[15];
      ref_flags[FV] = (m == INCW) ? (w == 16'h7FFF) : (w == 16'h8000);
      lat = 5;
    end else if (m == DA) begin
      if (!ref_flags[FD]) begin
        hc = ref_flags[FC] || (dv > 8'h99);
        r  = dv + ((ref_flags[FH] || dv[3:0] > 4'd9) ? 8'h06 : 8'h00) + (hc ? 8'h60 : 8'h00);
      end else begin
        hc = ref_flags[FC];
        r  = dv - (ref_flags[FH] ? 8'h06 : 8'h00) - (hc ? 8'h60 : 8'h00);
      end
      ew_a.push_back(d); ew_d.push_back(r);
      ref_flags[FC] = hc; ref_flags[FZ] = (r == 8'h00); ref_flags[FS] = r[7];
      lat = 4;
    end else begin
      a  = (m == LD) ? sv : dv;
      rr = alu_fn(m, a, sv, ref_flags);
      if (!(m == CP || m == TM || m == TCM)) begin
        ew_a.push_back(d); ew_d.push_back(rr[15:8]);
      end
      ref_flags = rr[7:0];
      if (m == CLR)     lat = 2;
      else if (m == LD) lat = im ? 2 : 3;
      else if (!m[4])   lat = im ? 3 : 4;
      else              lat = 3;
    end
    foreach (ew_a[i]) ref_rf[ew_a[i]] = ew_d[i];
  endtask

  task automatic do_cmd(input logic [4:0] m, input logic [7:0] d, input logic [7:0] s,
                        input logic im, input logic fwe, input logic [7:0] fin);
    int exp_lat, lat;
    @(negedge clk);
    op = m; dst = d; src = s; srcImm = im; start = 1'b1;
    flagsWe = fwe; flagsIn = fin;
    if (fwe) ref_flags = fin;
    ref_exec(m, d, s, im, exp_lat);
    wa_q.delete(); wd_q.delete();
    @(posedge clk); #1;
    start = 1'b0; flagsWe = 1'b0;
    lat = 1;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("latency op%0h", m), lat, exp_lat);
    check("ready_at_done", {31'd0, ready}, 32'd1);
    check($sformatf("nwrites op%0h", m), wa_q.size(), ew_a.size());
    foreach (ew_a[i]) begin
      if (i < wa_q.size()) begin
        check("wr_addr", {24'd0, wa_q[i]}, {24'd0, ew_a[i]});
        check("wr_data", {24'd0, wd_q[i]}, {24'd0, ew_d[i]});
      end
    end
    check($sformatf("flags op%0h", m), {24'd0, flags}, {24'd0, ref_flags});
    @(posedge clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  logic [4:0] ops [18] = '{ADD, ADC, SUB, SBC, OR_, AND_, TCM, TM, CP, XOR_,
                           LD, CLR, COM, INC, DEC, DA, INCW, DECW};

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; op = '0; dst = '0; src = '0; srcImm = 1'b0;
    flagsWe = 1'b0; flagsIn = '0; tb_we = 1'b0; tb_wa = '0; tb_wd = '0;
    ref_flags = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_regWe", {31'd0, regWe}, 32'd0);
    check("rst_regAddr", {24'd0, regAddr}, 32'd0);
    check("rst_regWrData", {24'd0, regWrData}, 32'd0);
    check("rst_flags", {24'd0, flags}, 32'd0);
    check("idle_alu", {11'd0, aluMode, aluA, aluB}, 32'd0);

    for (int i = 0; i < 256; i++) poke(i[7:0], 8'($urandom));

    // ADD register source
    poke(8'h0A, 8'h3A); poke(8'h0B, 8'hC7);
    do_cmd(ADD, 8'h0A, 8'h0B, 1'b0, 1'b0, 8'h00);
    check("add_r10", {24'd0, rf[8'h0A]}, 32'h01);
    check("add_flags", {24'd0, flags}, 32'h84);

    // INCW across a byte carry
    poke(8'h20, 8'h12); poke(8'h21, 8'hFF);
    do_cmd(INCW, 8'h21, 8'h00, 1'b0, 1'b0, 8'h00);
    check("incw_lo", {24'd0, rf[8'h21]}, 32'h00);
    check("incw_hi", {24'd0, rf[8'h20]}, 32'h13);
    check("incw_zv", {30'd0, flags[FZ], flags[FV]}, 32'd0);

    // DA after an add
    load_flags(8'h00);
    poke(8'h30, 8'h3C);
    do_cmd(DA, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00);
    check("da_r30", {24'd0, rf[8'h30]}, 32'h42);
    check("da_c", {31'd0, flags[FC]}, 32'd0);

    // CP immediate: no write
    poke(8'h05, 8'h05);
    do_cmd(CP, 8'h05, 8'h05, 1'b1, 1'b0, 8'h00);
    check("cp_zc", {30'd0, flags[FZ], flags[FC]}, 32'b10);

    // Reset in cycle 3 of INCW: low byte written, high byte untouched
    poke(8'h20, 8'h12); poke(8'h21, 8'hFF);
    @(negedge clk);
    op = INCW; dst = 8'h21; src = 8'h00; srcImm = 1'b0; start = 1'b1;
    wa_q.delete(); wd_q.delete();
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    check("rst_mid_regWe", {31'd0, regWe}, 32'd0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_mid_lo", {24'd0, rf[8'h21]}, 32'h00);
    check("rst_mid_hi", {24'd0, rf[8'h20]}, 32'h12);
    check("rst_mid_flags", {24'd0, flags}, 32'h00);
    check("rst_mid_ready", {31'd0, ready}, 32'd1);
    check("rst_mid_nwr", wa_q.size(), 32'd1);
    ref_rf[8'h21] = 8'h00;
    ref_flags = 8'h00;

    // Busy-ignore: start and flagsWe during an ALU2 register command
    poke(8'h40, 8'h10); poke(8'h41, 8'h20);
    @(negedge clk);
    op = ADD; dst = 8'h40; src = 8'h41; srcImm = 1'b0; start = 1'b1;
    wa_q.delete(); wd_q.delete();
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    op = CLR; dst = 8'h40; start = 1'b1; flagsWe = 1'b1; flagsIn = 8'hFF;
    @(posedge clk); #1; start = 1'b0; flagsWe = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(posedge clk); #1;
    end
    check("busy_dones", dones, 32'd1);
    check("busy_nwr", wa_q.size(), 32'd1);
    check("busy_r40", {24'd0, rf[8'h40]}, 32'h30);
    check("busy_flags", {24'd0, flags}, 32'h00);
    ref_rf[8'h40] = 8'h30;
    ref_flags = 8'h00;

    // flagsWe together with start: command sees the loaded carry
    poke(8'h42, 8'h01);
    do_cmd(ADC, 8'h42, 8'h01, 1'b1, 1'b1, 8'h80);
    check("adc_carry_in", {24'd0, rf[8'h42]}, 32'h03);

    // Randomized commands
    for (int n = 0; n < 80; n++) begin
      logic fwe;
      fwe = ($urandom_range(0, 3) == 0);
      do_cmd(ops[$urandom_range(0, 17)], 8'($urandom), 8'($urandom),
             1'($urandom), fwe, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that sequences the Z8 ALU for one instruction at a time. It fetches operands from the register file and drives the combinational ALU, chaining passes where needed: word INCW/DECW and two-pass DA. It then writes results back and owns the architectural FLAGS register. It sits between the instruction decoder (command handshake) and the register-file/ALU datapath.

## Interface
- No parameters. Mode codes are the `ALU1_*`/`ALU2_*` constants of alu.vh. Flag bit positions are those of flags.vh.
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  command valid; accepted only when ready=1
- ready  out  1  idle and able to accept a command
- done  out  1  one-cycle pulse: command complete
- op  in  5  ALU mode for the command
- dst  in  8  destination register address
- src  in  8  source register address, or immediate value when srcImm=1
- srcImm  in  1  src is an immediate
- regAddr  out  8  register-file address
- regRdData  in  8  combinational read data for regAddr
- regWrData  out  8  write data
- regWe  out  1  register write strobe, one cycle
- aluMode  out  5  to ALU mode
- aluA, aluB  out  8  to ALU operands
- aluFlags  out  8  to ALU flag input
- aluOut, aluOutFlags  in  8  from ALU
- flagsIn  in  8  external FLAGS load value
- flagsWe  in  1  external FLAGS load
- flags  out  8  FLAGS register

## Operation
- States: IDLE, RD_SRC, RD_DST, EXEC, RD_HI, EXEC_HI, DA_H.
- In IDLE with start=1, op/dst/src/srcImm are latched. Command classes:
  - CLR: IDLE → EXEC.
  - LD: RD_SRC (skipped if srcImm) → EXEC, with aluA = source.
  - Other ALU1 ops (except INCW/DECW/DA): RD_DST → EXEC, with aluA = dst value.
  - ALU2 ops: RD_SRC (skipped if srcImm) → RD_DST → EXEC, with aluA = dst value and aluB = source.
  - INCW/DECW: uses the pair hi = {dst[7:1],0}, lo = {dst[7:1],1}; dst[0] is ignored. Sequence: RD_DST(lo) → EXEC with ALU1_INC/ALU1_DEC, writing lo and capturing the low result L → RD_HI → EXEC_HI with ALU1_INCW/ALU1_DECW, aluA = hi, aluB = L, writing hi.
  - DA: RD_DST → EXEC with ALU1_DA, capturing out T and flags F, with no write → DA_H with ALU1_DA_H, aluA = T, aluFlags = F, writing {aluOut[7:4], T[3:0]}.
- Writeback happens in the final ALU cycle: regWe=1, regAddr = dst (or hi), regWrData = aluOut. CP, TM and TCM never write.
- FLAGS update:
  - FLAGS loads aluOutFlags in the final ALU cycle only. Intermediate passes (INCW low, DA low) never update FLAGS.
  - aluFlags = flags in every non-DA_H cycle.
  - flagsWe loads flagsIn only when ready=1. If flagsWe and start occur in the same cycle, the load takes effect and the command sees the loaded value.
- Ignored inputs: start while ready=0 is ignored, as is flagsWe while busy.
- Idle outputs: in IDLE, regAddr=0 and aluMode/aluA/aluB=0.

## Timing
- Cycle 0 is the clock edge sampling start. Done is asserted in the cycle after the final write/ALU cycle, and ready returns to 1 in that same cycle; a new start may be accepted then.
- done is asserted in cycle:
  - CLR: 2
  - LD immediate: 2
  - LD register: 3
  - ALU1 byte: 3
  - ALU2 immediate: 3
  - ALU2 register: 4
  - DA: 4
  - INCW/DECW: 5
- Register reads: regRdData is sampled at the end of the cycle that drives regAddr.
- Reset values: ready=1, done=0, regWe=0, regAddr=0, regWrData=0, flags=0x00, state IDLE.
- Reset mid-command aborts immediately. Writes already performed (e.g. an INCW low byte) persist; no further regWe is issued.

## Test plan
- ADD, register source: r10=0x3A, r11=0xC7, start op=ADD dst=0x0A src=0x0B. Expect r10=0x01; C=1, H=1, Z=0, S=0, V=0, D=0; done in cycle 4.
- INCW: r20=0x12, r21=0xFF, dst=0x21. Expect r21=0x00 then r20=0x13 (two regWe pulses, lo first); Z=0, V=0; done in cycle 5.
- DA after add: flags D=0, H=0, C=0; r30=0x3C; DA dst=0x30. Expect r30=0x42, C=0, one regWe; done in cycle 4.
- CP immediate: r05=0x05, src=0x05, srcImm=1. Expect regWe never asserted, Z=1, C=0; done in cycle 3.
- Reset during INCW: assert reset in cycle 3 of the scenario 2 INCW. Expect r21 already 0x00, r20 unchanged at 0x12, flags=0, ready=1 after release.
- Busy-ignore: during an ALU2 register command, pulse start and flagsWe (flagsIn=0xFF). Expect no second command, flags driven by the ALU result only. Then flagsWe+start together in IDLE with flagsIn=C set, ADC 0x01+0x01, gives 0x03.
